// File: rtl/dbus_if.sv
// dbus_if: N-master DBus request side plus the shared slave port and grant vector.
interface dbus_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable;
  logic [NUM_MASTERS-1:0] m_read;
  logic [NUM_MASTERS-1:0] m_write;
  logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic [NUM_MASTERS-1:0] m_stall;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W/8-1:0] s_byteenable;
  logic s_read;
  logic s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;
  logic s_stall;
  logic [NUM_MASTERS-1:0] grant;
  modport master (
    output m_address, m_byteenable, m_read, m_write, m_writedata, s_readdata, s_stall,
    input  m_readdata, m_stall, s_address, s_byteenable, s_read, s_write, s_writedata, grant
  );
  modport slave (
    input  m_address, m_byteenable, m_read, m_write, m_writedata, s_readdata, s_stall,
    output m_readdata, m_stall, s_address, s_byteenable, s_read, s_write, s_writedata, grant
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: N-to-1 DBus arbiter with registered one-hot grant held for one transfer.
module dbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ARB_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  dbus_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int LW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [LW-1:0] g, g_nx, last, last_nx, win;
  logic [NUM_MASTERS-1:0] grant, grant_nx, req;
  logic busy, done;
  function automatic logic [LW-1:0] slot(input int k, input logic [LW-1:0] l);
    return LW'((ARB_MODE != 0 ? k - 1 : int'(l) + k) % NUM_MASTERS);
  endfunction
  assign req = bus.m_read | bus.m_write;
  assign busy = state == BUSY;
  assign done = busy & req[g] & ~bus.s_stall;
  // Scan from the farthest candidate inward so the nearest requester overwrites the rest.
  always_comb begin
    win = '0;
    for (int k = NUM_MASTERS; k >= 1; k--)
      if (req[slot(k, last)]) win = slot(k, last);
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    g_nx = g;
    last_nx = last;
    if (!busy && |req) begin
      state_nx = BUSY;
      g_nx = win;
      grant_nx = NUM_MASTERS'(1) << win;
    end else if (busy && (!req[g] || !bus.s_stall)) begin
      state_nx = IDLE;
      grant_nx = '0;
      last_nx = done ? g : last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      g <= '0;
      last <= LW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      g <= g_nx;
      last <= last_nx;
    end
  end
  assign bus.grant = grant;
  assign bus.m_stall = ~(grant & {NUM_MASTERS{busy & ~bus.s_stall}});
  assign bus.m_readdata = bus.s_readdata;
  assign bus.s_address = busy ? bus.m_address[g*ADDR_W +: ADDR_W] : '0;
  assign bus.s_byteenable = busy ? bus.m_byteenable[g*BE_W +: BE_W] : '0;
  assign bus.s_writedata = busy ? bus.m_writedata[g*DATA_W +: DATA_W] : '0;
  assign bus.s_read = busy & bus.m_read[g];
  assign bus.s_write = busy & bus.m_write[g];
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed checks of a 4-master round-robin and a 3-master fixed-priority arbiter.
module tb_dbus_arbiter;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  dbus_if #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) a();
  dbus_if #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) b();
  dbus_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(a));
  dbus_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_all();
    a.m_read = '0; a.m_write = '0; a.m_address = '0; a.m_byteenable = '0; a.m_writedata = '0;
    a.s_readdata = '0; a.s_stall = 0;
    b.m_read = '0; b.m_write = '0; b.m_address = '0; b.m_byteenable = '0; b.m_writedata = '0;
    b.s_readdata = '0; b.s_stall = 0;
  endtask

  task automatic req_a(input int i, input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    a.m_read[i] = rd;
    a.m_write[i] = wr;
    a.m_address[i*32 +: 32] = addr;
    a.m_writedata[i*32 +: 32] = data;
    a.m_byteenable[i*4 +: 4] = 4'hF;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    cyc();
    req_a(0, 1, 0, 32'h100, 32'h0);
    cyc();
    #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=%b", a.grant, 4'b0000); end
    checks++; if (a.m_stall !== 4'b1111) begin errors++; $display("FAIL rst_stall got=%b exp=%b", a.m_stall, 4'b1111); end
    checks++; if (a.s_read !== 1'b0 || a.s_address !== 32'h0) begin errors++; $display("FAIL rst_sbus got=%b/%h exp=0/0", a.s_read, a.s_address); end
    checks++; if (b.m_stall !== 3'b111) begin errors++; $display("FAIL rst_stall_fp got=%b exp=%b", b.m_stall, 3'b111); end
    do_reset();
  endtask

  task automatic test_single_read();
    req_a(0, 1, 0, 32'h100, 32'h0);
    a.s_readdata = 32'hDEADBEEF;
    #1;
    checks++; if (a.grant !== 4'b0000 || a.s_read !== 1'b0) begin errors++; $display("FAIL sr_idle got=%b/%b exp=0000/0", a.grant, a.s_read); end
    cyc(); #1;
    checks++; if (a.grant !== 4'b0001) begin errors++; $display("FAIL sr_grant got=%b exp=%b", a.grant, 4'b0001); end
    checks++; if (a.s_read !== 1'b1 || a.s_address !== 32'h100) begin errors++; $display("FAIL sr_sbus got=%b/%h exp=1/100", a.s_read, a.s_address); end
    checks++; if (a.m_stall !== 4'b1110) begin errors++; $display("FAIL sr_stall got=%b exp=%b", a.m_stall, 4'b1110); end
    checks++; if (a.m_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got=%h exp=deadbeef", a.m_readdata); end
    cyc();
    req_a(0, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (a.grant !== 4'b0000 || a.m_stall !== 4'b1111) begin errors++; $display("FAIL sr_back_idle got=%b/%b exp=0000/1111", a.grant, a.m_stall); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_a(0, 0, 1, 32'h10, 32'h1111_0000);
    req_a(1, 0, 1, 32'h20, 32'h2222_0000);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] eg;
      logic [31:0] ed;
      eg = 4'b0001 << (k % 2);
      ed = 32'h1111_0000 * ((k % 2) + 1);
      cyc(); #1;
      checks++; if (a.grant !== eg) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, a.grant, eg); end
      checks++; if (a.s_writedata !== ed || a.s_write !== 1'b1) begin errors++; $display("FAIL rr_wdata%0d got=%h/%b exp=%h/1", k, a.s_writedata, a.s_write, ed); end
      checks++; if (a.m_stall !== ~eg) begin errors++; $display("FAIL rr_stall%0d got=%b exp=%b", k, a.m_stall, ~eg); end
      cyc(); #1;
      checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL rr_bubble%0d got=%b exp=0000", k, a.grant); end
    end
    idle_all();
  endtask

  task automatic test_slave_stall();
    cyc();
    req_a(1, 0, 1, 32'h44, 32'hA5A5A5A5);
    a.s_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      checks++; if (a.grant !== 4'b0010 || a.s_write !== 1'b1) begin errors++; $display("FAIL ss_hold%0d got=%b/%b exp=0010/1", k, a.grant, a.s_write); end
      checks++; if (a.s_writedata !== 32'hA5A5A5A5 || a.s_byteenable !== 4'hF) begin errors++; $display("FAIL ss_data%0d got=%h/%h exp=a5a5a5a5/f", k, a.s_writedata, a.s_byteenable); end
      checks++; if (a.m_stall !== 4'b1111) begin errors++; $display("FAIL ss_stall%0d got=%b exp=1111", k, a.m_stall); end
    end
    cyc();
    a.s_stall = 0;
    #1;
    checks++; if (a.m_stall !== 4'b1101 || a.s_write !== 1'b1) begin errors++; $display("FAIL ss_done got=%b/%b exp=1101/1", a.m_stall, a.s_write); end
    cyc();
    idle_all();
    #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL ss_idle got=%b exp=0000", a.grant); end
  endtask

  task automatic test_wrap();
    cyc();
    req_a(3, 1, 0, 32'h300, 32'h0);
    cyc(); #1;
    checks++; if (a.grant !== 4'b1000) begin errors++; $display("FAIL wr_first got=%b exp=1000", a.grant); end
    cyc();
    req_a(0, 1, 0, 32'h0, 32'h0);
    #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL wr_idle got=%b exp=0000", a.grant); end
    cyc(); #1;
    checks++; if (a.grant !== 4'b0001) begin errors++; $display("FAIL wr_wrap got=%b exp=0001", a.grant); end
    cyc();
    req_a(0, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL wr_idle2 got=%b exp=0000", a.grant); end
    cyc(); #1;
    checks++; if (a.grant !== 4'b1000 || a.s_address !== 32'h300) begin errors++; $display("FAIL wr_then3 got=%b/%h exp=1000/300", a.grant, a.s_address); end
    cyc();
    idle_all();
  endtask

  task automatic test_abort();
    do_reset();
    req_a(0, 1, 0, 32'h40, 32'h0);
    a.s_stall = 1;
    cyc(); #1;
    checks++; if (a.grant !== 4'b0001 || a.s_read !== 1'b1 || a.m_stall !== 4'b1111) begin errors++; $display("FAIL ab_busy got=%b/%b/%b exp=0001/1/1111", a.grant, a.s_read, a.m_stall); end
    a.m_read[0] = 0;
    #1;
    checks++; if (a.s_read !== 1'b0) begin errors++; $display("FAIL ab_drop got=%b exp=0", a.s_read); end
    cyc(); #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL ab_idle got=%b exp=0000", a.grant); end
    req_a(0, 1, 0, 32'h40, 32'h0);
    req_a(1, 1, 0, 32'h50, 32'h0);
    a.s_stall = 0;
    cyc(); #1;
    checks++; if (a.grant !== 4'b0001) begin errors++; $display("FAIL ab_ptr got=%b exp=0001", a.grant); end
    cyc();
    idle_all();
  endtask

  task automatic test_reset_mid();
    cyc();
    req_a(2, 1, 0, 32'h200, 32'h0);
    a.s_stall = 1;
    cyc(); #1;
    checks++; if (a.grant !== 4'b0100 || a.s_read !== 1'b1) begin errors++; $display("FAIL rm_busy got=%b/%b exp=0100/1", a.grant, a.s_read); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (a.grant !== 4'b0000) begin errors++; $display("FAIL rm_grant got=%b exp=0000", a.grant); end
    checks++; if (a.s_read !== 1'b0 || a.m_stall !== 4'b1111) begin errors++; $display("FAIL rm_outs got=%b/%b exp=0/1111", a.s_read, a.m_stall); end
    cyc();
    rst_n = 1;
    a.s_stall = 0;
    req_a(0, 1, 0, 32'h10, 32'h0);
    cyc(); #1;
    checks++; if (a.grant !== 4'b0001) begin errors++; $display("FAIL rm_first got=%b exp=0001", a.grant); end
    cyc();
    idle_all();
  endtask

  task automatic test_fixed_priority();
    cyc();
    b.m_write[1] = 1;
    b.m_write[2] = 1;
    #1;
    checks++; if (b.grant !== 3'b000) begin errors++; $display("FAIL fp_idle got=%b exp=000", b.grant); end
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      checks++; if (b.grant !== 3'b010 || b.m_stall !== 3'b101) begin errors++; $display("FAIL fp_m1_%0d got=%b/%b exp=010/101", k, b.grant, b.m_stall); end
      cyc(); #1;
      checks++; if (b.grant !== 3'b000 || b.m_stall !== 3'b111) begin errors++; $display("FAIL fp_gap%0d got=%b/%b exp=000/111", k, b.grant, b.m_stall); end
    end
    b.m_write[1] = 0;
    cyc(); #1;
    checks++; if (b.grant !== 3'b100 || b.m_stall !== 3'b011) begin errors++; $display("FAIL fp_m2 got=%b/%b exp=100/011", b.grant, b.m_stall); end
    cyc();
    idle_all();
    #1;
    checks++; if (b.grant !== 3'b000) begin errors++; $display("FAIL fp_end got=%b exp=000", b.grant); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_slave_stall();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_fixed_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
